joy_dir_filter: RTL and testbench
=================================

# joy_dir_filter

Multi-channel joystick conditioner between `hps_io` joystick outputs and the core input-port mux in arcade cores. It generalises the one-direction mask to N players, adds selectable restriction modes (pass-through, 4-way last-wins, 4-way first-wins, 2-way horizontal), and adds a per-channel autofire generator paced by a frame strobe. All outputs are registered, so the block drops into any core's `clk_sys` domain without glitching the input ports.

## Interface
- `CHANNELS`, default 2: number of independent players.
- `AF_RATE_W`, default 4: width of the autofire rate field.
- `clk  in  1`: core system clock.
- `reset  in  1`: synchronous, active-high reset.
- `mode  in  2`: direction mode. 00 = pass, 01 = 4-way last-wins, 10 = 4-way first-wins, 11 = 2-way horizontal.
- `ce_frame  in  1`: one-cycle strobe per video frame, e.g. the vblank rising edge.
- `joy_in  in  4*CHANNELS`: per channel `{up,down,left,right}`, channel 0 in the LSBs.
- `fire_in  in  CHANNELS`: raw fire button per channel.
- `af_en  in  CHANNELS`: autofire enable per channel.
- `af_rate  in  AF_RATE_W`: frames per half-period, minus 1.
- `joy_out  out  4*CHANNELS`: filtered directions, same packing as `joy_in`.
- `fire_out  out  CHANNELS`: filtered fire.

## Operation
- **Input sync.** Per channel, `s1 <= joy_in` and `s2 <= s1`. A direction edge is `e = s1 & ~s2`.
- **Lock state.** Each channel holds `lock`, either FREE (encoded 4'b1111) or a one-hot direction. `next_lock` is computed combinationally, then `lock <= next_lock` and `joy_out <= s1 & next_lock`.
- **Priority** for simultaneous bits is fixed: up > down > left > right.
- **mode 00.** `next_lock` = FREE and `joy_out` = `s1`.
- **mode 01, last-wins.** Evaluated in this order:
  - If `e != 0`, lock to the highest-priority bit of `e`.
  - Else if `lock` is one-hot and `(s1 & lock) == 0`, lock to the highest-priority bit of `s1`, or FREE if `s1 == 0`.
  - Else if `lock` is FREE and `s1 != 0`, lock to the highest-priority bit of `s1`.
  - Result: `joy_out` never has more than one bit set.
- **mode 10, first-wins.** Same as mode 01, except new edges are ignored while the lock is one-hot and still held.
- **mode 11.** Up and down are forced to 0 before filtering: `s1` is masked to `{2'b00, s1[1:0]}` for both lock logic and output. Left/right use mode-01 rules.
- **Mode change.** A change of `mode` is detected against a registered copy. On the cycle it is detected, every channel's `next_lock` becomes FREE, then the normal rules apply from the following cycle.
- **Autofire, per channel.** State is `afcnt` (width `AF_RATE_W`) and `phase`.
  - If `!af_en`: `fire_out <= fire_in` (registered, 1 cycle).
  - If `af_en` and `fire_in == 0`: `afcnt <= 0`, `phase <= 1`, `fire_out <= 0`.
  - If `af_en` and `fire_in == 1`: `fire_out <= phase`. On each `ce_frame`, if `afcnt == af_rate`, then `afcnt <= 0` and `phase` toggles; else `afcnt` increments.
  - The first press always yields an immediate high phase.
- **Reset values:** `s1`, `s2`, `joy_out`, `fire_out`, `afcnt` = 0; `lock` = FREE; `phase` = 1; registered mode = 00.

## Timing
- `joy_in` to `joy_out`: 2 cycles (sync register, then output register).
- `fire_in` to `fire_out`: 1 cycle.
- Lock decisions and `joy_out` update on the same edge, so there is no one-cycle multi-bit output after a new press.
- `ce_frame` coincident with fire release: release wins, and the counter clears.
- `ce_frame` on the same cycle as the fire press: counts as frame 0 with `phase` = 1.
- `reset` mid-lock or mid-autofire: all state returns to reset values on the next edge, and outputs are 0 one cycle later.
- `af_rate` changed during autofire takes effect at the next `ce_frame` compare. If `afcnt > af_rate`, the counter keeps incrementing until it wraps modulo 2^AF_RATE_W, then compares normally. No special handling.

## Structure
- Package `joy_pkg` holds:
  - the mode enum (`JM_PASS`, `JM_LAST`, `JM_FIRST`, `JM_HORIZ`);
  - direction bit indices (`D_UP`=3, `D_DOWN`=2, `D_LEFT`=1, `D_RIGHT`=0);
  - the `LOCK_FREE` constant;
  - a priority-select function returning the highest-priority set bit.
- Sub-module `joy_chan`, one per player, contains sync, lock, and autofire. The top instantiates it `CHANNELS` times via generate and owns the registered-mode compare, broadcasting a `mode_chg` pulse.

## Test plan
- **Pass mode:** mode 00, `joy_in` ch0 = 4'b1010 → `joy_out` ch0 = 4'b1010 exactly 2 cycles later.
- **Last-wins:** mode 01, hold right (0001) 5 cycles, then add up (1001) → `joy_out` = 0001, then 1000. Release up while right is held → `joy_out` = 0001.
- **First-wins:** mode 10, hold left (0010), then add down (0110) → `joy_out` stays 0010. Release left → 0100.
- **Simultaneous press, 2-way:** from idle, press 1100 → `joy_out` = 1000. Same stimulus in mode 11 → 0000. Press 0011 in mode 11 → 0010.
- **Autofire:** `af_en`=1, `af_rate`=1, fire held, `ce_frame` every 10 cycles → `fire_out` is 1 for 2 frames, 0 for 2 frames, repeating. Release → 0 after 1 cycle.
- **Reset and mode change:** assert `reset` mid-lock with autofire active → all outputs 0 next cycle, `lock` FREE. Change mode 01→10 while locked → lock goes FREE, then relocks to the held direction.

Source files
------------

// File: rtl/joy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : joy_pkg
//  Description : Shared types, direction indices and priority helper for the
//                joystick direction filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package joy_pkg;

    typedef enum logic [1:0] {
        JM_PASS  = 2'b00,
        JM_LAST  = 2'b01,
        JM_FIRST = 2'b10,
        JM_HORIZ = 2'b11
    } joy_mode_e;

    localparam int D_UP    = 3;
    localparam int D_DOWN  = 2;
    localparam int D_LEFT  = 1;
    localparam int D_RIGHT = 0;

    localparam logic [3:0] LOCK_FREE = 4'b1111;

    // Highest-priority set bit (up > down > left > right), zero if none set.
    function automatic logic [3:0] prio_sel(input logic [3:0] v);
        logic [3:0] r;
        r = 4'b0000;
        if (v[D_UP])         r[D_UP]    = 1'b1;
        else if (v[D_DOWN])  r[D_DOWN]  = 1'b1;
        else if (v[D_LEFT])  r[D_LEFT]  = 1'b1;
        else if (v[D_RIGHT]) r[D_RIGHT] = 1'b1;
        return r;
    endfunction

endpackage : joy_pkg
`default_nettype wire

// File: rtl/joy_dir_filter_chan.sv
`default_nettype none
// ============================================================================
//  Module      : joy_chan
//  Description : One player's input sync, direction lock and autofire.
//  Revision    : 1.0 - initial release
// ============================================================================
module joy_chan
    import joy_pkg::*;
#(
    parameter int AF_RATE_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  joy_mode_e            mode,
    input  logic                 mode_chg,
    input  logic                 ce_frame,
    input  logic [3:0]           joy_in,
    input  logic                 fire_in,
    input  logic                 af_en,
    input  logic [AF_RATE_W-1:0] af_rate,
    output logic [3:0]           joy_out,
    output logic                 fire_out
);

    logic [3:0]           r_s1;
    logic [3:0]           r_s2;
    logic [3:0]           r_lock;
    logic [AF_RATE_W-1:0] r_afcnt;
    logic                 r_phase;

    logic [3:0] w_s1m;
    logic [3:0] w_edge;
    logic       w_locked;
    logic       w_held;
    logic [3:0] w_next_lock;

    // Horizontal mode hides up/down from both the lock logic and the output.
    assign w_s1m    = (mode == JM_HORIZ) ? {2'b00, r_s1[1:0]} : r_s1;
    assign w_edge   = w_s1m & ~r_s2;
    assign w_locked = (r_lock != LOCK_FREE);
    assign w_held   = ((w_s1m & r_lock) != 4'b0000);

    always_comb begin
        w_next_lock = r_lock;
        if (mode_chg || mode == JM_PASS) begin
            w_next_lock = LOCK_FREE;
        end else if (w_edge != 4'b0000 && !(mode == JM_FIRST && w_locked && w_held)) begin
            w_next_lock = prio_sel(w_edge);
        end else if (w_locked && !w_held) begin
            w_next_lock = (w_s1m == 4'b0000) ? LOCK_FREE : prio_sel(w_s1m);
        end else if (!w_locked && w_s1m != 4'b0000) begin
            w_next_lock = prio_sel(w_s1m);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1    <= 4'b0000;
            r_s2    <= 4'b0000;
            r_lock  <= LOCK_FREE;
            joy_out <= 4'b0000;
        end else begin
            r_s1    <= joy_in;
            r_s2    <= r_s1;
            r_lock  <= w_next_lock;
            joy_out <= w_s1m & w_next_lock;
        end
    end

    // Release outranks a coincident frame strobe; a fresh press starts high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_afcnt  <= '0;
            r_phase  <= 1'b1;
            fire_out <= 1'b0;
        end else if (!af_en) begin
            fire_out <= fire_in;
        end else if (!fire_in) begin
            r_afcnt  <= '0;
            r_phase  <= 1'b1;
            fire_out <= 1'b0;
        end else begin
            fire_out <= r_phase;
            if (ce_frame) begin
                if (r_afcnt == af_rate) begin
                    r_afcnt <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_afcnt <= r_afcnt + AF_RATE_W'(1);
                end
            end
        end
    end

endmodule : joy_chan
`default_nettype wire

// File: rtl/joy_dir_filter.sv
`default_nettype none
// ============================================================================
//  Module      : joy_dir_filter
//  Description : N-player joystick conditioner with direction restriction
//                modes and frame-paced autofire; all outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module joy_dir_filter
    import joy_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int AF_RATE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic                  ce_frame,
    input  logic [4*CHANNELS-1:0] joy_in,
    input  logic [CHANNELS-1:0]   fire_in,
    input  logic [CHANNELS-1:0]   af_en,
    input  logic [AF_RATE_W-1:0]  af_rate,
    output logic [4*CHANNELS-1:0] joy_out,
    output logic [CHANNELS-1:0]   fire_out
);

    joy_mode_e w_mode;
    joy_mode_e r_mode;
    logic      w_mode_chg;

    assign w_mode     = joy_mode_e'(mode);
    assign w_mode_chg = (w_mode != r_mode);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode <= JM_PASS;
        end else begin
            r_mode <= w_mode;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        joy_chan #(
            .AF_RATE_W (AF_RATE_W)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .mode     (w_mode),
            .mode_chg (w_mode_chg),
            .ce_frame (ce_frame),
            .joy_in   (joy_in[4*g +: 4]),
            .fire_in  (fire_in[g]),
            .af_en    (af_en[g]),
            .af_rate  (af_rate),
            .joy_out  (joy_out[4*g +: 4]),
            .fire_out (fire_out[g])
        );
    end

endmodule : joy_dir_filter
`default_nettype wire

// File: tb/tb_joy_dir_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_joy_dir_filter
//  Description : Directed self-checking bench for joy_dir_filter (2 players).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_joy_dir_filter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       ce_frame;
    logic [7:0] joy_in;
    logic [1:0] fire_in;
    logic [1:0] af_en;
    logic [3:0] af_rate;
    logic [7:0] joy_out;
    logic [1:0] fire_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    joy_dir_filter #(
        .CHANNELS  (2),
        .AF_RATE_W (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .ce_frame (ce_frame),
        .joy_in   (joy_in),
        .fire_in  (fire_in),
        .af_en    (af_en),
        .af_rate  (af_rate),
        .joy_out  (joy_out),
        .fire_out (fire_out)
    );

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic frame();
        ce_frame = 1'b1;
        step(1);
        ce_frame = 1'b0;
        step(9);
    endtask

    initial begin
        reset = 1'b1; mode = 2'b00; ce_frame = 1'b0; joy_in = 8'h00;
        fire_in = 2'b00; af_en = 2'b00; af_rate = 4'd1;
        step(2);
        reset = 1'b0;
        check("reset_joy", joy_out, 8'h00);
        check("reset_fire", {6'd0, fire_out}, 8'h00);

        // Pass mode, 2-cycle latency
        joy_in = 8'h5A;
        step(1);
        check("pass_lat1", joy_out, 8'h00);
        step(1);
        check("pass_lat2", joy_out, 8'h5A);

        // Last-wins
        joy_in = 8'h00; mode = 2'b01;
        step(4);
        check("last_idle", joy_out, 8'h00);
        joy_in = 8'h01;
        step(5);
        check("last_right", joy_out, 8'h01);
        joy_in = 8'h09;
        step(1);
        check("last_add_up_c1", joy_out, 8'h01);
        step(1);
        check("last_add_up_c2", joy_out, 8'h08);
        joy_in = 8'h01;
        step(2);
        check("last_rel_up", joy_out, 8'h01);
        joy_in = 8'h03;
        step(2);
        check("last_add_left", joy_out, 8'h02);

        // Mode change frees the lock for one cycle, then relocks
        mode = 2'b10;
        step(1);
        check("mchg_free", joy_out, 8'h03);
        step(1);
        check("mchg_relock", joy_out, 8'h02);

        // First-wins
        joy_in = 8'h00;
        step(3);
        joy_in = 8'h02;
        step(2);
        check("first_left", joy_out, 8'h02);
        joy_in = 8'h06;
        step(2);
        check("first_add_down", joy_out, 8'h02);
        step(2);
        check("first_hold", joy_out, 8'h02);
        joy_in = 8'h04;
        step(2);
        check("first_rel_left", joy_out, 8'h04);

        // Simultaneous press, priority and 2-way horizontal
        joy_in = 8'h00; mode = 2'b01;
        step(4);
        joy_in = 8'h0C;
        step(2);
        check("simul_last", joy_out, 8'h08);
        joy_in = 8'h00; mode = 2'b11;
        step(4);
        joy_in = 8'h0C;
        step(2);
        check("horiz_updown", joy_out, 8'h00);
        step(2);
        check("horiz_updown_hold", joy_out, 8'h00);
        joy_in = 8'h00;
        step(3);
        joy_in = 8'h93;
        step(2);
        check("horiz_lr", joy_out, 8'h12);

        // Autofire on ch0 (rate 1), plain fire on ch1
        joy_in = 8'h00; mode = 2'b00; af_en = 2'b01; af_rate = 4'd1;
        step(3);
        fire_in = 2'b11;
        step(1);
        check("af_press", {6'd0, fire_out}, 8'h03);
        step(8);
        frame();
        check("af_frame1", {6'd0, fire_out}, 8'h03);
        frame();
        check("af_frame2", {6'd0, fire_out}, 8'h02);
        frame();
        check("af_frame3", {6'd0, fire_out}, 8'h02);
        frame();
        check("af_frame4", {6'd0, fire_out}, 8'h03);
        fire_in = 2'b10; ce_frame = 1'b1;
        step(1);
        ce_frame = 1'b0;
        check("af_release_ce", {6'd0, fire_out}, 8'h02);
        fire_in = 2'b00;
        step(1);
        check("plain_release", {6'd0, fire_out}, 8'h00);

        // Reset mid-lock with autofire active
        mode = 2'b01; joy_in = 8'h01; fire_in = 2'b01;
        step(4);
        check("pre_rst_joy", joy_out, 8'h01);
        check("pre_rst_fire", {6'd0, fire_out}, 8'h01);
        reset = 1'b1;
        step(1);
        check("rst_joy", joy_out, 8'h00);
        check("rst_fire", {6'd0, fire_out}, 8'h00);
        reset = 1'b0;
        step(1);
        check("post_rst_joy1", joy_out, 8'h00);
        check("post_rst_fire", {6'd0, fire_out}, 8'h01);
        step(1);
        check("post_rst_joy2", joy_out, 8'h01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_joy_dir_filter
`default_nettype wire
